// File: rtl/max2d_window_buffer_pkg.sv
// ============================================================================
// Module : max2d_window_buffer_pkg
// Brief  : Shared widths, FSM encoding and helpers for the max-pool window buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef BIT_DATA
`define BIT_DATA 8
`endif
`ifndef MAX2D_KSIZE
`define MAX2D_KSIZE 4
`endif
`ifndef MAX2D_STRIDE
`define MAX2D_STRIDE 2
`endif

package max2d_window_buffer_pkg;

  localparam int unsigned BIT_DATA_W = `BIT_DATA;
  localparam int unsigned KSIZE      = `MAX2D_KSIZE;
  localparam int unsigned STRIDE     = `MAX2D_STRIDE;

  localparam int unsigned SLOT_TL = 0;
  localparam int unsigned SLOT_TR = 1;
  localparam int unsigned SLOT_BL = 2;
  localparam int unsigned SLOT_BR = 3;

  typedef enum logic [1:0] {
    ST_TOP    = 2'd0,
    ST_BOTTOM = 2'd1,
    ST_DROP   = 2'd2
  } win_state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/max2d_line_buffer.sv
// ============================================================================
// Module : max2d_line_buffer
// Brief  : One row of pixel storage, one write port, two combinational reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max2d_line_buffer #(
  parameter int unsigned DEPTH = 26,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = 5
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // No reset: every entry is rewritten by a top row before it is read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/max2d_window_buffer.sv
// ============================================================================
// Module : max2d_window_buffer
// Brief  : Builds 2x2 stride-2 pooling windows from a raster pixel stream.
//          Optional MAX2D_WINBUF_SOF_EN adds an in_sof frame-resync input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max2d_window_buffer
  import max2d_window_buffer_pkg::*;
#(
  parameter int unsigned FILTER_IN = 32,
  parameter int unsigned IMG_W     = 26,
  parameter int unsigned IMG_H     = 26
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
`ifdef MAX2D_WINBUF_SOF_EN
  input  logic                                         in_sof,
`endif
  input  logic [`BIT_DATA*FILTER_IN-1:0]               x,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [`BIT_DATA*`MAX2D_KSIZE*FILTER_IN-1:0]  y,
  output logic                                         out_last
);

  localparam int unsigned PIX_W  = BIT_DATA_W * FILTER_IN;
  localparam int unsigned SLOT_W = BIT_DATA_W * KSIZE;
  localparam int unsigned WIN_W  = SLOT_W * FILTER_IN;
  localparam int unsigned CW     = addr_width(IMG_W);
  localparam int unsigned RW     = addr_width(IMG_H);

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_PRE_DROP = RW'(IMG_H - 2);
  localparam logic [RW-1:0] LAST_WIN_ROW = RW'((IMG_H / 2) * 2 - 1);
  localparam logic [CW-1:0] LAST_WIN_COL = CW'((IMG_W / 2) * 2 - 1);
  localparam bit            H_ODD        = (IMG_H % 2) == 1;

  if (KSIZE != STRIDE * STRIDE) begin : g_ksize_check
    $error("MAX2D_KSIZE must equal MAX2D_STRIDE squared");
  end

  win_state_e       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] bl_q, bl_d;
  logic [WIN_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             ready_en_q, ready_en_d;

  logic             accept;
  logic             sof;
  logic             win_fire;
  logic             lb_wr_en;
  logic [CW-1:0]    lb_wr_addr;
  logic [CW-1:0]    lb_rd_prev_addr;
  logic [PIX_W-1:0] lb_rd_prev;
  logic [PIX_W-1:0] lb_rd_cur;
  logic [WIN_W-1:0] win;

`ifdef MAX2D_WINBUF_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  // ready_en_q keeps in_ready low for the first cycle after reset release.
  assign in_ready        = ready_en_q && (!out_valid_q || out_ready);
  assign accept          = in_valid && in_ready;
  assign lb_rd_prev_addr = col_q - 1'b1;

  max2d_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_line_buffer (
    .clock     (clock),
    .wr_en     (lb_wr_en),
    .wr_addr   (lb_wr_addr),
    .wr_data   (x),
    .rd_addr_a (lb_rd_prev_addr),
    .rd_data_a (lb_rd_prev),
    .rd_addr_b (col_q),
    .rd_data_b (lb_rd_cur)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < int'(FILTER_IN); i++) begin
      win[i*SLOT_W + SLOT_TL*BIT_DATA_W +: BIT_DATA_W] = lb_rd_prev[i*BIT_DATA_W +: BIT_DATA_W];
      win[i*SLOT_W + SLOT_TR*BIT_DATA_W +: BIT_DATA_W] = lb_rd_cur[i*BIT_DATA_W +: BIT_DATA_W];
      win[i*SLOT_W + SLOT_BL*BIT_DATA_W +: BIT_DATA_W] = bl_q[i*BIT_DATA_W +: BIT_DATA_W];
      win[i*SLOT_W + SLOT_BR*BIT_DATA_W +: BIT_DATA_W] = x[i*BIT_DATA_W +: BIT_DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    bl_d       = bl_q;
    lb_wr_en   = 1'b0;
    lb_wr_addr = col_q;
    win_fire   = 1'b0;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      unique case (state_q)
        ST_TOP: begin
          lb_wr_en = 1'b1;
          if (col_q == COL_LAST) begin
            state_d = ST_BOTTOM;
          end
        end
        ST_BOTTOM: begin
          // Odd columns complete a window; a trailing even column just lands in bl.
          if (col_q[0]) begin
            win_fire = 1'b1;
          end else begin
            bl_d = x;
          end
          if (col_q == COL_LAST) begin
            state_d = (H_ODD && (row_q == ROW_PRE_DROP)) ? ST_DROP : ST_TOP;
          end
        end
        ST_DROP: begin
          if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
            state_d = ST_TOP;
          end
        end
        default: state_d = ST_TOP;
      endcase

      if (sof) begin
        state_d    = ST_TOP;
        col_d      = CW'(1);
        row_d      = '0;
        bl_d       = '0;
        lb_wr_en   = 1'b1;
        lb_wr_addr = '0;
        win_fire   = 1'b0;
      end
    end
  end

  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ready_en_d  = 1'b1;
    if (win_fire) begin
      y_d         = win;
      out_valid_d = 1'b1;
      out_last_d  = (row_q == LAST_WIN_ROW) && (col_q == LAST_WIN_COL);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_TOP;
      col_q       <= '0;
      row_q       <= '0;
      bl_q        <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bl_q        <= bl_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign y         = y_q;

endmodule

`default_nettype wire

// File: tb/tb_max2d_window_buffer.sv
// ============================================================================
// Module : tb_max2d_window_buffer
// Brief  : Self-checking bench for max2d_window_buffer (4x4 and 5x5 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef BIT_DATA
`define BIT_DATA 8
`endif
`ifndef MAX2D_KSIZE
`define MAX2D_KSIZE 4
`endif

module tb_max2d_window_buffer;

  localparam int FI = 2;
  localparam int BD = `BIT_DATA;
  localparam int PW = BD * FI;
  localparam int YW = BD * `MAX2D_KSIZE * FI;

  typedef logic [3:0][BD-1:0] win4_t;

  typedef struct packed {
    logic             sel;
    logic [7:0]       mult;
    logic             neg;
    logic             bp;
    logic [3:0][3:0][BD-1:0] exp;
  } frame_vec_t;

  typedef struct packed {
    logic [YW-1:0] y;
    logic          last;
  } exp_t;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic          drv_valid = 1'b0;
  logic          drv_sof = 1'b0;
  logic [PW-1:0] drv_x = '0;
  logic          drv_ready = 1'b1;
  int            ready_ctl = 1;

  logic          iv4, ir4, ov4, ol4;
  logic          iv5, ir5, ov5, ol5;
  logic [YW-1:0] y4, y5;
  logic          mon_valid, mon_last, mon_in_ready;
  logic [YW-1:0] mon_y;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_win = 0;
  bit   abort = 1'b0;
  frame_vec_t vecs [5];

  always #5 clock = ~clock;

  assign iv4          = drv_valid & ~sel;
  assign iv5          = drv_valid & sel;
  assign mon_valid    = sel ? ov5 : ov4;
  assign mon_last     = sel ? ol5 : ol4;
  assign mon_y        = sel ? y5 : y4;
  assign mon_in_ready = sel ? ir5 : ir4;

  max2d_window_buffer #(.FILTER_IN(FI), .IMG_W(4), .IMG_H(4)) dut4 (
    .clock     (clock),
    .reset     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
`ifdef MAX2D_WINBUF_SOF_EN
    .in_sof    (drv_sof),
`endif
    .x         (drv_x),
    .out_valid (ov4),
    .out_ready (drv_ready),
    .y         (y4),
    .out_last  (ol4)
  );

  max2d_window_buffer #(.FILTER_IN(FI), .IMG_W(5), .IMG_H(5)) dut5 (
    .clock     (clock),
    .reset     (rst_n),
    .in_valid  (iv5),
    .in_ready  (ir5),
`ifdef MAX2D_WINBUF_SOF_EN
    .in_sof    (drv_sof),
`endif
    .x         (drv_x),
    .out_valid (ov5),
    .out_ready (drv_ready),
    .y         (y5),
    .out_last  (ol5)
  );

  always @(posedge clock) begin
    #1;
    case (ready_ctl)
      0:       drv_ready = 1'b0;
      1:       drv_ready = 1'b1;
      default: drv_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic win4_t w4(input int a, input int b, input int c, input int d);
    return {BD'(d), BD'(c), BD'(b), BD'(a)};
  endfunction

  function automatic logic [YW-1:0] mk_y(input win4_t s, input bit neg);
    logic [YW-1:0] r;
    logic [BD-1:0] v;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      v = s[j];
      r[j*BD +: BD] = v;
      r[4*BD + j*BD +: BD] = neg ? -v : v;
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] mk_x(input int v, input bit neg);
    logic [BD-1:0] b;
    b = BD'(v);
    return {neg ? -b : b, b};
  endfunction

  // Transfer happens at the next posedge when valid && ready hold at negedge.
  always @(negedge clock) begin
    if (mon_valid && drv_ready) begin
      n_win++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_window: got y=%h expected none", mon_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("win%0d_y", n_win), mon_y, e.y);
        chk($sformatf("win%0d_last", n_win), YW'(mon_last), YW'(e.last));
      end
    end
  end

  task automatic send_pix(input int v, input bit neg, input bit sof);
    int n;
    if (abort) return;
    drv_x = mk_x(v, neg);
    drv_sof = sof;
    drv_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clock);
      if (mon_in_ready) break;
    end
    if (n == 200) begin
      n_chk++;
      abort = 1'b1;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
    end
    @(posedge clock);
    #1;
    drv_valid = 1'b0;
    drv_sof = 1'b0;
  endtask

  task automatic send_frame(input int dim, input int mult, input int off, input bit neg, input bit sof0);
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++)
        send_pix(mult * r + c + off, neg, sof0 && (r == 0) && (c == 0));
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0 && !mon_valid) break;
      @(negedge clock);
    end
    chk("queue_empty", YW'(exp_q.size()), YW'(0));
  endtask

  task automatic run_vec(input frame_vec_t v, input int k);
    int base;
    sel = v.sel;
    ready_ctl = v.bp ? 2 : 1;
    @(posedge clock);
    #1;
    base = n_win;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{y: mk_y(v.exp[i], v.neg), last: (i == 3)});
    send_frame(v.sel ? 5 : 4, int'(v.mult), 0, v.neg, 1'b0);
    drain();
    chk($sformatf("vec%0d_windows", k), YW'(n_win - base), YW'(4));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    vecs[0] = '{sel: 1'b0, mult: 8'd4, neg: 1'b0, bp: 1'b0,
                exp: {w4(10,11,14,15), w4(8,9,12,13), w4(2,3,6,7), w4(0,1,4,5)}};
    vecs[1] = '{sel: 1'b0, mult: 8'd4, neg: 1'b1, bp: 1'b1,
                exp: {w4(10,11,14,15), w4(8,9,12,13), w4(2,3,6,7), w4(0,1,4,5)}};
    vecs[2] = '{sel: 1'b1, mult: 8'd5, neg: 1'b0, bp: 1'b0,
                exp: {w4(12,13,17,18), w4(10,11,15,16), w4(2,3,7,8), w4(0,1,5,6)}};
    vecs[3] = '{sel: 1'b1, mult: 8'd5, neg: 1'b1, bp: 1'b1,
                exp: {w4(12,13,17,18), w4(10,11,15,16), w4(2,3,7,8), w4(0,1,5,6)}};
    vecs[4] = '{sel: 1'b0, mult: 8'd4, neg: 1'b1, bp: 1'b0,
                exp: {w4(10,11,14,15), w4(8,9,12,13), w4(2,3,6,7), w4(0,1,4,5)}};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid4", YW'(ov4), YW'(0));
    chk("rst_out_last4", YW'(ol4), YW'(0));
    chk("rst_y4", y4, '0);
    chk("rst_in_ready4", YW'(ir4), YW'(0));
    chk("rst_out_valid5", YW'(ov5), YW'(0));
    chk("rst_y5", y5, '0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", YW'(ir4), YW'(0));
    @(posedge clock);
    #1;
    chk("ready_after_release", YW'(ir4), YW'(1));

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Backpressure: out_ready low across the first window
    sel = 1'b0;
    ready_ctl = 0;
    @(posedge clock);
    #1;
    base = n_win;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{y: mk_y(vecs[0].exp[i], 1'b0), last: (i == 3)});
    fork
      send_frame(4, 4, 0, 1'b0, 1'b0);
      begin
        int n;
        for (n = 0; n < 100; n++) begin
          @(negedge clock);
          if (mon_valid) break;
        end
        chk("bp_first_valid", YW'(n < 100), YW'(1));
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          chk("bp_hold_valid", YW'(mon_valid), YW'(1));
          chk("bp_hold_y", mon_y, mk_y(vecs[0].exp[0], 1'b0));
          chk("bp_hold_in_ready", YW'(mon_in_ready), YW'(0));
        end
        ready_ctl = 1;
      end
    join
    drain();
    chk("bp_windows", YW'(n_win - base), YW'(4));

    // Reset in the middle of a frame, then a clean frame
    ready_ctl = 1;
    for (int c = 0; c < 5; c++) send_pix(c < 4 ? c : 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", YW'(ov4), YW'(0));
    chk("midrst_out_last", YW'(ol4), YW'(0));
    chk("midrst_y", y4, '0);
    chk("midrst_in_ready", YW'(ir4), YW'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    run_vec(vecs[0], 10);

`ifdef MAX2D_WINBUF_SOF_EN
    // Resync at row 2 col 1: that pixel becomes the new origin
    sel = 1'b0;
    ready_ctl = 1;
    @(posedge clock);
    #1;
    base = n_win;
    exp_q.push_back('{y: mk_y(w4(0,1,4,5), 1'b0), last: 1'b0});
    exp_q.push_back('{y: mk_y(w4(2,3,6,7), 1'b0), last: 1'b0});
    exp_q.push_back('{y: mk_y(w4(64,65,68,69), 1'b0), last: 1'b0});
    exp_q.push_back('{y: mk_y(w4(66,67,70,71), 1'b0), last: 1'b0});
    exp_q.push_back('{y: mk_y(w4(72,73,76,77), 1'b0), last: 1'b0});
    exp_q.push_back('{y: mk_y(w4(74,75,78,79), 1'b0), last: 1'b1});
    for (int p = 0; p < 9; p++) send_pix(p, 1'b0, 1'b0);
    send_frame(4, 4, 64, 1'b0, 1'b1);
    drain();
    chk("sof_windows", YW'(n_win - base), YW'(6));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
